// File: rtl/gobang_pkg.sv
// Shared constants for the gobang move controller: FSM state codes, cell encodings, board default.
package gobang_pkg;

  localparam int DEF_BOARD_SIZE = 15;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOOKUP = 2'd1;
  localparam logic [1:0] ST_PLACE  = 2'd2;
  localparam logic [1:0] ST_UNDO   = 2'd3;

  typedef enum logic [1:0] {
    CELL_EMPTY = 2'd0,
    CELL_BLACK = 2'd1,
    CELL_WHITE = 2'd2
  } cell_e;

  // Stone colour written for the side to move (0 = black, 1 = white).
  function automatic logic [1:0] stone_of(input logic side);
    return side ? CELL_WHITE : CELL_BLACK;
  endfunction

endpackage

// File: rtl/gobang_cursor.sv
// Registered board cursor: one arrow step per enabled cycle with wrap or clamp at the edges,
// or a direct load (used to return to the undone cell). Load has priority over stepping.
module gobang_cursor
  import gobang_pkg::*;
#(
  parameter int BOARD_SIZE = DEF_BOARD_SIZE,
  parameter int COORD_W    = 4,
  parameter int WRAP       = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               step_en,
  input  logic               key_up,
  input  logic               key_down,
  input  logic               key_left,
  input  logic               key_right,
  input  logic               load,
  input  logic [COORD_W-1:0] load_x,
  input  logic [COORD_W-1:0] load_y,
  output logic [COORD_W-1:0] cur_x,
  output logic [COORD_W-1:0] cur_y
);

  localparam logic [COORD_W-1:0] MAX_C    = COORD_W'(BOARD_SIZE - 1);
  localparam logic [COORD_W-1:0] CENTER_C = COORD_W'(BOARD_SIZE / 2);

  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;

  function automatic logic [COORD_W-1:0] step_dn(input logic [COORD_W-1:0] v);
    if (v == '0) return (WRAP != 0) ? MAX_C : '0;
    return v - 1'b1;
  endfunction

  function automatic logic [COORD_W-1:0] step_up(input logic [COORD_W-1:0] v);
    if (v == MAX_C) return (WRAP != 0) ? '0 : MAX_C;
    return v + 1'b1;
  endfunction

  // Up/left win over their opposites; the two axes update independently.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (load) begin
      x_d = load_x;
      y_d = load_y;
    end else if (step_en) begin
      if (key_up)         y_d = step_dn(y_q);
      else if (key_down)  y_d = step_up(y_q);
      if (key_left)       x_d = step_dn(x_q);
      else if (key_right) x_d = step_up(x_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q <= CENTER_C;
      y_q <= CENTER_C;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign cur_x = x_q;
  assign cur_y = y_q;

endmodule

// File: rtl/gobang_move_ctrl.sv
// Turn/move sequencer: key pulses -> cursor moves, occupancy lookup, req/ack stone writes,
// turn tracking and single-level undo. Keys arriving while busy are dropped.
module gobang_move_ctrl
  import gobang_pkg::*;
#(
  parameter int BOARD_SIZE = DEF_BOARD_SIZE,
  parameter int COORD_W    = 4,
  parameter int CNT_W      = 8,
  parameter int WRAP       = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               key_up,
  input  logic               key_down,
  input  logic               key_left,
  input  logic               key_right,
  input  logic               key_ok,
  input  logic               key_switch,
  input  logic               key_reverse,
  input  logic               game_over,
  input  logic               cell_occ,
  input  logic               wr_ack,
  output logic [COORD_W-1:0] cur_x,
  output logic [COORD_W-1:0] cur_y,
  output logic               player,
  output logic               wr_req,
  output logic [COORD_W-1:0] wr_x,
  output logic [COORD_W-1:0] wr_y,
  output logic [1:0]         wr_val,
  output logic [CNT_W-1:0]   move_cnt,
  output logic               board_full,
  output logic               placed,
  output logic               rejected,
  output logic               busy
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BOARD_SIZE * BOARD_SIZE);

  logic [1:0]         state_q, state_d;
  logic               player_q, player_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               undo_q, undo_d;
  logic [COORD_W-1:0] last_x_q, last_x_d, last_y_q, last_y_d;
  logic [COORD_W-1:0] wr_x_q, wr_x_d, wr_y_q, wr_y_d;
  logic [1:0]         wr_val_q, wr_val_d;
  logic               placed_q, placed_d, rejected_q, rejected_d;
  logic               step_en, cur_load;

  gobang_cursor #(
    .BOARD_SIZE (BOARD_SIZE),
    .COORD_W    (COORD_W),
    .WRAP       (WRAP)
  ) u_cursor (
    .clk       (clk),
    .rst       (rst),
    .step_en   (step_en),
    .key_up    (key_up),
    .key_down  (key_down),
    .key_left  (key_left),
    .key_right (key_right),
    .load      (cur_load),
    .load_x    (last_x_q),
    .load_y    (last_y_q),
    .cur_x     (cur_x),
    .cur_y     (cur_y)
  );

  assign board_full = (cnt_q == FULL_CNT);

  // IDLE serves only the highest-priority key present; a refused key still consumes the cycle.
  always_comb begin
    state_d    = state_q;
    player_d   = player_q;
    cnt_d      = cnt_q;
    undo_d     = undo_q;
    last_x_d   = last_x_q;
    last_y_d   = last_y_q;
    wr_x_d     = wr_x_q;
    wr_y_d     = wr_y_q;
    wr_val_d   = wr_val_q;
    placed_d   = 1'b0;
    rejected_d = 1'b0;
    step_en    = 1'b0;
    cur_load   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (key_reverse) begin
          if (undo_q) begin
            state_d  = ST_UNDO;
            wr_x_d   = last_x_q;
            wr_y_d   = last_y_q;
            wr_val_d = CELL_EMPTY;
          end
        end else if (key_ok) begin
          if (!game_over && !board_full) state_d = ST_LOOKUP;
        end else if (key_switch) begin
          if (cnt_q == '0) player_d = ~player_q;
        end else begin
          step_en = 1'b1;
        end
      end
      ST_LOOKUP: begin
        if (cell_occ) begin
          rejected_d = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          wr_x_d   = cur_x;
          wr_y_d   = cur_y;
          wr_val_d = stone_of(player_q);
          state_d  = ST_PLACE;
        end
      end
      ST_PLACE: begin
        if (wr_ack) begin
          last_x_d = wr_x_q;
          last_y_d = wr_y_q;
          undo_d   = 1'b1;
          cnt_d    = cnt_q + 1'b1;
          player_d = ~player_q;
          placed_d = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: begin
        if (wr_ack) begin
          cnt_d    = cnt_q - 1'b1;
          player_d = ~player_q;
          undo_d   = 1'b0;
          cur_load = 1'b1;
          state_d  = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      player_q   <= 1'b0;
      cnt_q      <= '0;
      undo_q     <= 1'b0;
      last_x_q   <= '0;
      last_y_q   <= '0;
      wr_x_q     <= '0;
      wr_y_q     <= '0;
      wr_val_q   <= CELL_EMPTY;
      placed_q   <= 1'b0;
      rejected_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      player_q   <= player_d;
      cnt_q      <= cnt_d;
      undo_q     <= undo_d;
      last_x_q   <= last_x_d;
      last_y_q   <= last_y_d;
      wr_x_q     <= wr_x_d;
      wr_y_q     <= wr_y_d;
      wr_val_q   <= wr_val_d;
      placed_q   <= placed_d;
      rejected_q <= rejected_d;
    end
  end

  assign player   = player_q;
  assign move_cnt = cnt_q;
  assign wr_req   = (state_q == ST_PLACE) || (state_q == ST_UNDO);
  assign wr_x     = wr_x_q;
  assign wr_y     = wr_y_q;
  assign wr_val   = wr_val_q;
  assign placed   = placed_q;
  assign rejected = rejected_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_gobang_move_ctrl.sv
// Bench: directed scenarios plus random key traffic against a move-level reference model.
module tb_gobang_move_ctrl;

  localparam int N = 15;

  logic clk;
  logic rst, key_up, key_down, key_left, key_right, key_ok, key_switch, key_reverse;
  logic game_over, cell_occ, wr_ack;

  logic [3:0] a_cur_x, a_cur_y, a_wr_x, a_wr_y;
  logic       a_player, a_wr_req, a_board_full, a_placed, a_rejected, a_busy;
  logic [1:0] a_wr_val;
  logic [7:0] a_move_cnt;

  logic [3:0] b_cur_x, b_cur_y, b_wr_x, b_wr_y;
  logic       b_player, b_wr_req, b_board_full, b_placed, b_rejected, b_busy;
  logic [1:0] b_wr_val;
  logic [7:0] b_move_cnt;

  int errors = 0;
  int checks = 0;

  // Board RAM seen by the wrapping DUT, and the model's own view of the board.
  logic [1:0] ram [0:15][0:15];
  int         mb  [0:N-1][0:N-1];
  int m_x, m_y, m_p, m_cnt, m_undo, m_lx, m_ly;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  gobang_move_ctrl #(.BOARD_SIZE(15), .COORD_W(4), .CNT_W(8), .WRAP(1)) dut (
    .clk(clk), .rst(rst), .key_up(key_up), .key_down(key_down), .key_left(key_left),
    .key_right(key_right), .key_ok(key_ok), .key_switch(key_switch), .key_reverse(key_reverse),
    .game_over(game_over), .cell_occ(cell_occ), .wr_ack(wr_ack),
    .cur_x(a_cur_x), .cur_y(a_cur_y), .player(a_player), .wr_req(a_wr_req),
    .wr_x(a_wr_x), .wr_y(a_wr_y), .wr_val(a_wr_val), .move_cnt(a_move_cnt),
    .board_full(a_board_full), .placed(a_placed), .rejected(a_rejected), .busy(a_busy));

  gobang_move_ctrl #(.BOARD_SIZE(15), .COORD_W(4), .CNT_W(8), .WRAP(0)) dut_clamp (
    .clk(clk), .rst(rst), .key_up(key_up), .key_down(key_down), .key_left(key_left),
    .key_right(key_right), .key_ok(key_ok), .key_switch(key_switch), .key_reverse(key_reverse),
    .game_over(game_over), .cell_occ(1'b0), .wr_ack(1'b0),
    .cur_x(b_cur_x), .cur_y(b_cur_y), .player(b_player), .wr_req(b_wr_req),
    .wr_x(b_wr_x), .wr_y(b_wr_y), .wr_val(b_wr_val), .move_cnt(b_move_cnt),
    .board_full(b_board_full), .placed(b_placed), .rejected(b_rejected), .busy(b_busy));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // All stimulus and sampling happens on the falling edge; the RAM read data follows the cursor.
  task automatic tick();
    @(negedge clk);
    cell_occ = (ram[a_cur_x][a_cur_y] != 2'd0);
  endtask

  task automatic model_reset();
    m_x = N / 2; m_y = N / 2; m_p = 0; m_cnt = 0; m_undo = 0; m_lx = 0; m_ly = 0;
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++) begin
        ram[i][j] = 2'd0;
        if (i < N && j < N) mb[i][j] = 0;
      end
  endtask

  task automatic do_reset();
    {key_up, key_down, key_left, key_right, key_ok, key_switch, key_reverse} = '0;
    game_over = 1'b0; wr_ack = 1'b0; rst = 1'b1;
    model_reset();
    tick(); tick();
    chk("rst_cur_x", a_cur_x, 7);
    chk("rst_cur_y", a_cur_y, 7);
    chk("rst_player", a_player, 0);
    chk("rst_move_cnt", a_move_cnt, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_wr_req", a_wr_req, 0);
    chk("rst_placed", a_placed, 0);
    chk("rst_rejected", a_rejected, 0);
    chk("rst_board_full", a_board_full, 0);
    rst = 1'b0;
  endtask

  // One key event: predict its outcome from the game rules, apply it, serve the write port, compare.
  task automatic do_op(input bit u, input bit dn, input bit l, input bit r, input bit ok,
                       input bit sw, input bit rev, input bit go, input int dly, input bit stray);
    int exp_wr, exp_pl, exp_rj, exp_wx, exp_wy, exp_wv, exp_first;
    int got_wr, pl, rj, req_cycles, first_req, cd, cd0, c;
    logic [3:0] gx, gy;
    logic [1:0] gv;
    exp_wr = 0; exp_pl = 0; exp_rj = 0; exp_wx = 0; exp_wy = 0; exp_wv = 0; exp_first = 0;
    if (rev) begin
      if (m_undo != 0) begin
        exp_wr = 1; exp_wx = m_lx; exp_wy = m_ly; exp_wv = 0; exp_first = 0;
        mb[m_lx][m_ly] = 0;
        m_cnt--; m_p = 1 - m_p; m_undo = 0; m_x = m_lx; m_y = m_ly;
      end
    end else if (ok) begin
      if (!go && m_cnt != N * N) begin
        if (mb[m_x][m_y] != 0) exp_rj = 1;
        else begin
          exp_wr = 1; exp_pl = 1; exp_wx = m_x; exp_wy = m_y; exp_wv = m_p + 1; exp_first = 1;
          mb[m_x][m_y] = m_p + 1;
          m_lx = m_x; m_ly = m_y; m_undo = 1; m_cnt++; m_p = 1 - m_p;
        end
      end
    end else if (sw) begin
      if (m_cnt == 0) m_p = 1 - m_p;
    end else begin
      if (u) m_y = (m_y + N - 1) % N; else if (dn) m_y = (m_y + 1) % N;
      if (l) m_x = (m_x + N - 1) % N; else if (r) m_x = (m_x + 1) % N;
    end

    game_over = go;
    {key_up, key_down, key_left, key_right, key_ok, key_switch, key_reverse} = {u, dn, l, r, ok, sw, rev};
    tick();
    {key_up, key_down, key_left, key_right, key_ok, key_switch, key_reverse} = '0;

    got_wr = 0; pl = 0; rj = 0; req_cycles = 0; first_req = -1; gx = '0; gy = '0; gv = '0;
    cd = (dly < 0) ? int'($urandom_range(0, 3)) : dly;
    cd0 = cd;
    c = 0;
    while (1) begin
      key_left = 1'b0;
      if (a_placed) pl++;
      if (a_rejected) rj++;
      wr_ack = 1'b0;
      if (a_wr_req) begin
        req_cycles++;
        if (first_req < 0) first_req = c;
        if (cd == 0) begin
          wr_ack = 1'b1; got_wr++;
          gx = a_wr_x; gy = a_wr_y; gv = a_wr_val;
          ram[gx][gy] = gv;
        end else cd--;
      end
      if (!a_busy && !wr_ack) break;
      if (c == 40) begin
        chk("op_timeout_busy", a_busy, 0);
        wr_ack = 1'b0;
        break;
      end
      if (stray && a_busy && $urandom_range(0, 1) == 1) key_left = 1'b1;
      tick();
      c++;
    end

    chk("writes", got_wr, exp_wr);
    if (exp_wr != 0) begin
      chk("wr_x", gx, exp_wx);
      chk("wr_y", gy, exp_wy);
      chk("wr_val", gv, exp_wv);
      chk("wr_req_cycles", req_cycles, cd0 + 1);
      chk("wr_req_latency", first_req, exp_first);
    end
    chk("placed_pulses", pl, exp_pl);
    chk("rejected_pulses", rj, exp_rj);
    chk("cur_x", a_cur_x, m_x);
    chk("cur_y", a_cur_y, m_y);
    chk("player", a_player, m_p);
    chk("move_cnt", a_move_cnt, m_cnt);
    chk("board_full", a_board_full, (m_cnt == N * N) ? 1 : 0);
    chk("wr_req_idle", a_wr_req, 0);
  endtask

  initial begin
    int ty;
    bit u, dn, l, r, ok, sw, rev;

    // Wrapping cursor: eight left steps from the centre.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      do_op(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      chk("wrap_left_x", a_cur_x, (i < 7) ? 6 - i : 14);
      chk("wrap_left_y", a_cur_y, 7);
    end

    // Clamping cursor: nine up steps pin y at zero.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      do_op(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("clamp_up_y", b_cur_y, (7 - i - 1 > 0) ? 7 - i - 1 : 0);
      chk("clamp_up_x", b_cur_x, 7);
    end

    // Placement with delayed ack, then rejection on the same cell.
    do_reset();
    do_op(0, 0, 0, 0, 1, 0, 0, 0, 3, 0);
    chk("first_stone_player", a_player, 1);
    do_op(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);

    // Undo, refused second undo, switch before and after the first stone.
    do_op(0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
    do_op(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    do_op(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    chk("switch_player", a_player, 1);
    do_op(0, 0, 0, 0, 1, 0, 0, 0, 2, 1);
    do_op(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);

    // ok and reverse together take the undo.
    do_op(0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
    chk("concurrent_undo_cnt", a_move_cnt, 0);

    // Reset in the middle of a placement write.
    key_ok = 1'b1; tick(); key_ok = 1'b0;
    tick();
    chk("place_wr_req", a_wr_req, 1);
    rst = 1'b1;
    tick();
    chk("midrst_wr_req", a_wr_req, 0);
    chk("midrst_busy", a_busy, 0);
    chk("midrst_cnt", a_move_cnt, 0);
    chk("midrst_player", a_player, 0);
    chk("midrst_placed", a_placed, 0);
    chk("midrst_cur_x", a_cur_x, 7);
    rst = 1'b0;
    model_reset();

    // Random key traffic, occasional game_over, stray keys while busy.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      ty = int'($urandom_range(0, 9));
      {u, dn, l, r, ok, sw, rev} = '0;
      case (ty)
        0, 1, 2, 9: {u, dn, l, r} = 4'($urandom_range(1, 15));
        3, 4, 5:    ok = 1'b1;
        6:          sw = 1'b1;
        7:          rev = 1'b1;
        default:    {u, dn, l, r, ok, sw, rev} = 7'($urandom_range(0, 127));
      endcase
      do_op(u, dn, l, r, ok, sw, rev, ($urandom_range(0, 7) == 0), -1, 1);
    end

    // Fill the whole board, then check the full-board lockout and undo from full.
    do_reset();
    for (int y = 0; y < N; y++) begin
      for (int x = 0; x < N; x++) begin
        do_op(0, 0, 0, 0, 1, 0, 0, 0, -1, 1);
        do_op(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
      end
      do_op(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    end
    chk("full_flag", a_board_full, 1);
    do_op(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    do_op(0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
    chk("after_undo_full", a_board_full, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
